// File: rtl/pcs_pkg.sv
// Shared 10G PCS definitions: sync header encodings, block-lock FSM states
// and default lock/error thresholds.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int LOCK_CNT_DEF = 64;
  localparam int ERR_MAX_DEF  = 16;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    TEST   = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } block_sync_state_t;

endpackage

// File: rtl/pcs_10g_block_sync.sv
// Clause 49 block-lock controller: hunts for 66b alignment by slipping the
// RX gearbox and reports block lock once sync headers are consistently valid.
module pcs_10g_block_sync
  import pcs_pkg::*;
#(
  parameter int HEAD_W     = 2,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int ERR_MAX    = ERR_MAX_DEF,
  parameter int SLIP_WAIT  = 4,
  parameter int SLIP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_locked_i,
  input  logic                  head_v_i,
  input  logic [HEAD_W-1:0]     head_i,
  output logic                  slip_v_o,
  output logic                  block_lock_o,
  output logic [SLIP_CNT_W-1:0] slip_cnt_o,
  output block_sync_state_t     state_o
);

  localparam int SH_W   = $clog2(LOCK_CNT + 1);
  localparam int INV_W  = $clog2(ERR_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  // Handshake: head_v_i qualifies head_i for one cycle, there is no back-pressure;
  // slip_v_o is a single-cycle request the gearbox must act on without acknowledge.

  block_sync_state_t state, state_nxt;
  logic [SH_W-1:0]   sh_cnt, sh_nxt, sh_inc;
  logic [INV_W-1:0]  inv_cnt, inv_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              slip_nxt, lock_nxt, hdr_ok;

  assign state_o = state;
  assign hdr_ok  = (head_i == HEAD_W'(SYNC_DATA)) || (head_i == HEAD_W'(SYNC_CTRL));
  assign sh_inc  = sh_cnt + SH_W'(1);

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh_cnt;
    inv_nxt   = inv_cnt;
    wait_nxt  = wait_cnt;
    slip_nxt  = 1'b0;
    lock_nxt  = block_lock_o;
    if (!rx_locked_i) begin
      state_nxt = INIT;
      sh_nxt    = '0;
      inv_nxt   = '0;
      wait_nxt  = '0;
      lock_nxt  = 1'b0;
    end else begin
      case (state)
        INIT: state_nxt = TEST;
        TEST: begin
          if (head_v_i) begin
            if (!hdr_ok) begin
              state_nxt = SLIP;
              sh_nxt    = '0;
              inv_nxt   = '0;
              wait_nxt  = '0;
              slip_nxt  = 1'b1;
            end else if (sh_inc == SH_W'(LOCK_CNT)) begin
              state_nxt = LOCKED;
              sh_nxt    = '0;
              inv_nxt   = '0;
              lock_nxt  = 1'b1;
            end else begin
              sh_nxt = sh_inc;
            end
          end
        end
        LOCKED: begin
          if (head_v_i) begin
            // Error limit is tested before the window end so a loss of lock
            // on the last header of a window is not masked by the window reset.
            if (!hdr_ok && (inv_cnt + INV_W'(1) == INV_W'(ERR_MAX))) begin
              state_nxt = SLIP;
              sh_nxt    = '0;
              inv_nxt   = '0;
              wait_nxt  = '0;
              slip_nxt  = 1'b1;
              lock_nxt  = 1'b0;
            end else if (sh_inc == SH_W'(LOCK_CNT)) begin
              sh_nxt  = '0;
              inv_nxt = '0;
            end else begin
              sh_nxt  = sh_inc;
              inv_nxt = inv_cnt + INV_W'(!hdr_ok);
            end
          end
        end
        SLIP: begin
          lock_nxt = 1'b0;
          // One request cycle, then SLIP_WAIT settling cycles before hunting again.
          if (wait_cnt == WAIT_W'(SLIP_WAIT)) begin
            state_nxt = TEST;
            wait_nxt  = '0;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= INIT;
      sh_cnt       <= '0;
      inv_cnt      <= '0;
      wait_cnt     <= '0;
      slip_v_o     <= 1'b0;
      block_lock_o <= 1'b0;
      slip_cnt_o   <= '0;
    end else begin
      state        <= state_nxt;
      sh_cnt       <= sh_nxt;
      inv_cnt      <= inv_nxt;
      wait_cnt     <= wait_nxt;
      slip_v_o     <= slip_nxt;
      block_lock_o <= lock_nxt;
      if (slip_nxt && (slip_cnt_o != '1)) begin
        slip_cnt_o <= slip_cnt_o + SLIP_CNT_W'(1);
      end
    end
  end

  a_head_known: assert property (@(posedge clk) disable iff (reset)
    head_v_i |-> !$isunknown(head_i));

endmodule

// File: tb/tb_pcs_10g_block_sync.sv
// Directed bench for pcs_10g_block_sync: single-header vector table plus
// multi-cycle lock, slip, window, gap, CDR-drop, reset and saturation sequences.
module tb_pcs_10g_block_sync;
  import pcs_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_locked_i;
  logic              head_v_i;
  logic [1:0]        head_i;
  logic              slip_v_o;
  logic              block_lock_o;
  logic [7:0]        slip_cnt_o;
  block_sync_state_t state_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_slip = 0;

  typedef struct {
    logic              hv;
    logic [1:0]        h;
    logic              exp_slip;
    block_sync_state_t exp_state;
    logic [7:0]        exp_cnt;
  } vec_t;
  vec_t tbl[5];

  pcs_10g_block_sync dut (
    .clk          (clk),
    .reset        (reset),
    .rx_locked_i  (rx_locked_i),
    .head_v_i     (head_v_i),
    .head_i       (head_i),
    .slip_v_o     (slip_v_o),
    .block_lock_o (block_lock_o),
    .slip_cnt_o   (slip_cnt_o),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read one falling edge later.
  task automatic step(input logic v, input logic [1:0] h);
    head_v_i = v;
    head_i   = v ? h : 2'bxx;
    @(negedge clk);
    if (slip_v_o) n_slip++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    rx_locked_i = 1'b1;
    head_v_i    = 1'b0;
    head_i      = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    n_slip = 0;
  endtask

  task automatic feed_valid(input int n);
    for (int i = 0; i < n; i++) step(1'b1, (i % 2 == 0) ? SYNC_DATA : SYNC_CTRL);
  endtask

  task automatic lock_up();
    do_reset();
    step(1'b0, 2'b00);
    feed_valid(64);
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'b00, 1'b1, SLIP, 8'd1};
    tbl[1] = '{1'b1, 2'b01, 1'b0, TEST, 8'd0};
    tbl[2] = '{1'b1, 2'b10, 1'b0, TEST, 8'd0};
    tbl[3] = '{1'b1, 2'b11, 1'b1, SLIP, 8'd1};
    tbl[4] = '{1'b0, 2'b11, 1'b0, TEST, 8'd0};

    // Reset values while reset is held.
    reset = 1'b1; rx_locked_i = 1'b1; head_v_i = 1'b0; head_i = 2'b00;
    @(negedge clk);
    chk("rst_state", int'(state_o), int'(INIT));
    chk("rst_lock", int'(block_lock_o), 0);
    chk("rst_slip", int'(slip_v_o), 0);
    chk("rst_cnt", int'(slip_cnt_o), 0);

    // Single header applied from a fresh TEST state.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      step(1'b0, 2'b00);
      step(tbl[i].hv, tbl[i].h);
      chk($sformatf("vec%0d_slip", i), int'(slip_v_o), int'(tbl[i].exp_slip));
      chk($sformatf("vec%0d_state", i), int'(state_o), int'(tbl[i].exp_state));
      chk($sformatf("vec%0d_cnt", i), int'(slip_cnt_o), int'(tbl[i].exp_cnt));
    end

    // Lock after 64 consecutive valid headers, not earlier.
    do_reset();
    step(1'b0, 2'b00);
    chk("init_to_test", int'(state_o), int'(TEST));
    feed_valid(63);
    chk("lock_after_63", int'(block_lock_o), 0);
    feed_valid(1);
    chk("lock_after_64", int'(block_lock_o), 1);
    chk("lock_no_slip", n_slip, 0);

    // Invalid header #30 while hunting; headers in SLIP are ignored.
    do_reset();
    step(1'b0, 2'b00);
    feed_valid(29);
    step(1'b1, 2'b11);
    chk("h30_slip", int'(slip_v_o), 1);
    chk("h30_cnt", int'(slip_cnt_o), 1);
    step(1'b1, 2'b11);
    chk("h30_pulse_end", int'(slip_v_o), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b00);
    chk("h30_back_test", int'(state_o), int'(TEST));
    chk("h30_one_slip", int'(slip_cnt_o), 1);
    feed_valid(63);
    chk("h30_relock_63", int'(block_lock_o), 0);
    feed_valid(1);
    chk("h30_relock_64", int'(block_lock_o), 1);

    // 15 invalid per window for 3 windows keeps lock.
    lock_up();
    for (int w = 0; w < 3; w++)
      for (int p = 1; p <= 64; p++)
        step(1'b1, (p % 4 == 0 && p <= 60) ? 2'b11 : SYNC_DATA);
    chk("win15_lock", int'(block_lock_o), 1);
    chk("win15_no_slip", n_slip, 0);
    // 16th invalid is the 64th header of the window.
    for (int p = 1; p <= 63; p++) step(1'b1, (p % 4 == 0) ? 2'b00 : SYNC_CTRL);
    chk("win16_pre", int'(block_lock_o), 1);
    step(1'b1, 2'b00);
    chk("win16_last_slip", int'(slip_v_o), 1);
    chk("win16_last_lock", int'(block_lock_o), 0);
    chk("win16_last_state", int'(state_o), int'(SLIP));

    // 16 consecutive invalid headers at the start of a window.
    lock_up();
    for (int i = 0; i < 15; i++) step(1'b1, 2'b11);
    chk("burst15_lock", int'(block_lock_o), 1);
    step(1'b1, 2'b11);
    chk("burst16_lock", int'(block_lock_o), 0);
    chk("burst16_slip", int'(slip_v_o), 1);
    step(1'b1, SYNC_DATA);
    chk("burst16_single", n_slip, 1);

    // Gaps: lock needs 64 valid headers regardless of gap cycles.
    do_reset();
    step(1'b0, 2'b00);
    for (int i = 0; i < 63; i++) begin
      step(1'b0, 2'b00);
      step(1'b1, SYNC_DATA);
    end
    step(1'b0, 2'b00);
    chk("gap_not_yet", int'(block_lock_o), 0);
    step(1'b1, SYNC_CTRL);
    chk("gap_lock", int'(block_lock_o), 1);

    // CDR lock lost for one cycle while locked.
    lock_up();
    rx_locked_i = 1'b0;
    step(1'b1, 2'b11);
    rx_locked_i = 1'b1;
    chk("cdr_lock", int'(block_lock_o), 0);
    chk("cdr_state", int'(state_o), int'(INIT));
    chk("cdr_slip", n_slip, 0);
    step(1'b0, 2'b00);
    feed_valid(63);
    chk("cdr_relock_63", int'(block_lock_o), 0);
    feed_valid(1);
    chk("cdr_relock_64", int'(block_lock_o), 1);

    // Asynchronous reset mid-window after one slip.
    do_reset();
    step(1'b0, 2'b00);
    step(1'b1, 2'b00);
    for (int i = 0; i < 5; i++) step(1'b0, 2'b00);
    feed_valid(74);
    chk("arst_pre_lock", int'(block_lock_o), 1);
    chk("arst_pre_cnt", int'(slip_cnt_o), 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_lock", int'(block_lock_o), 0);
    chk("arst_cnt", int'(slip_cnt_o), 0);
    chk("arst_state", int'(state_o), int'(INIT));
    @(negedge clk);
    reset = 1'b0;

    // Slip counter saturation.
    do_reset();
    step(1'b0, 2'b00);
    for (int s = 0; s < 260; s++) begin
      for (int i = 0; i < 6; i++) step(1'b1, 2'b11);
      if (s == 9) chk("sat_cnt_10", int'(slip_cnt_o), 10);
    end
    chk("sat_cnt", int'(slip_cnt_o), 255);
    chk("sat_pulses", n_slip, 260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
